// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter: index wrap arithmetic used for pointer rotation.
package rr_arb_pkg;

    localparam int RR_ARB_N_DEFAULT = 8;

    // Successor of idx in a ring of n requesters.
    function automatic int rr_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arb_dec.sv
// Binary-to-one-hot decoder: out_o[k] is set when in_i == k, for k below W.
module dec #(
    parameter int W     = 8,
    parameter int OUT_W = W,
    localparam int IN_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o
);

    always_comb begin
        out_o = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (k < W && in_i == IN_W'(k)) begin
                out_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb.sv
// Packet-level round-robin arbiter: locks a grant for a whole multi-beat transfer,
// then rotates priority past the released requester.
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int N     = RR_ARB_N_DEFAULT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     last_i,
    input  logic             ack_i,
    output logic             gnt_vld_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic [N-1:0]     gnt_o
);

    typedef enum logic {IDLE, LOCKED} rr_arb_state_t;

    rr_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     dec_out;
    logic             release_w;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) r = IDX_W'(k);
        end
        return r;
    endfunction

    // Requests at or above the pointer take precedence; otherwise wrap to the lowest one.
    function automatic logic [IDX_W-1:0] rr_find(input logic [N-1:0] req,
                                                 input logic [IDX_W-1:0] start);
        logic [N-1:0] hi_mask;
        logic [N-1:0] masked;
        for (int k = 0; k < N; k++) begin
            hi_mask[k] = (k >= int'(start));
        end
        masked = req & hi_mask;
        return (masked != '0) ? lowest_set(masked) : lowest_set(req);
    endfunction

    assign release_w = (state_q == LOCKED) && ack_i && last_i[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (req_i != '0) begin
                    state_d = LOCKED;
                    idx_d   = rr_find(req_i, ptr_q);
                end
            end
            LOCKED: begin
                if (release_w) begin
                    ptr_d = IDX_W'(rr_next_idx(int'(idx_q), N));
                    // The released index is last in search order from the new
                    // pointer, so it only wins again when it is the sole requester.
                    if (req_i != '0) begin
                        idx_d = rr_find(req_i, ptr_d);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    dec #(
        .W     (N),
        .OUT_W (N)
    ) u_dec (
        .in_i  (idx_q),
        .out_o (dec_out)
    );

    assign gnt_vld_o = (state_q == LOCKED);
    assign gnt_idx_o = idx_q;
    assign gnt_o     = dec_out & {N{gnt_vld_o}};

endmodule

// File: tb/tb_rr_arb.sv
// Directed bench for rr_arb with N = 4: the driver queues expected outputs, a monitor checks them.
module tb_rr_arb;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    // Entry layout: {chk, vld, idx[1:0], chk_ptr, ptr[1:0]}
    localparam int EW    = 7;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_i;
    logic [N-1:0]     last_i;
    logic             ack_i;
    logic             gnt_vld_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic [N-1:0]     gnt_o;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_cmp;
    int            n_bad;

    rr_arb #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .last_i    (last_i),
        .ack_i     (ack_i),
        .gnt_vld_o (gnt_vld_o),
        .gnt_idx_o (gnt_idx_o),
        .gnt_o     (gnt_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: apply inputs mid-cycle, queue what the outputs must be after the next edge.
    task automatic step(input logic r, input logic [N-1:0] req, input logic [N-1:0] last,
                        input logic ack, input string name, input logic chk,
                        input logic vld, input logic [IDX_W-1:0] idx,
                        input logic chkp, input logic [IDX_W-1:0] ptr);
        @(negedge clk);
        rst    = r;
        req_i  = req;
        last_i = last;
        ack_i  = ack;
        exp_q.push_back({chk, vld, idx, chkp, ptr});
        name_q.push_back(name);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [EW-1:0]    e;
        string            nm;
        logic [N-1:0]     exp_gnt;
        logic [IDX_W-1:0] exp_idx;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                exp_idx = e[4:3];
                exp_gnt = e[5] ? (N'(1) << exp_idx) : '0;
                if (e[6]) begin
                    n_cmp++;
                    if (gnt_vld_o !== e[5] || gnt_idx_o !== exp_idx || gnt_o !== exp_gnt) begin
                        n_bad++;
                        $display("FAIL %s: got vld=%0b idx=%0d gnt=%b, want vld=%0b idx=%0d gnt=%b",
                                 nm, gnt_vld_o, gnt_idx_o, gnt_o, e[5], exp_idx, exp_gnt);
                    end
                end
                if (e[2]) begin
                    n_cmp++;
                    if (dut.ptr_q !== e[1:0]) begin
                        n_bad++;
                        $display("FAIL %s ptr: got %0d, want %0d", nm, dut.ptr_q, e[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        req_i  = '0;
        last_i = '0;
        ack_i  = 1'b0;

        // Reset held with all requests pending, then first grant to index 0
        step(1, 4'b1111, 4'b0000, 0, "rst_hold0",   1, 0, 0, 1, 0);
        step(1, 4'b1111, 4'b0000, 0, "rst_hold1",   1, 0, 0, 1, 0);
        step(0, 4'b1111, 4'b0000, 0, "rst_release", 1, 1, 0, 1, 0);
        step(0, 4'b0000, 4'b0001, 1, "rst_done",    1, 0, 0, 1, 1);

        // Single requester
        step(1, 4'b0000, 4'b0000, 0, "s2_rst",      1, 0, 0, 1, 0);
        step(0, 4'b0100, 4'b0000, 0, "s2_grant",    1, 1, 2, 1, 0);
        step(0, 4'b0100, 4'b0000, 0, "s2_hold1",    1, 1, 2, 0, 0);
        step(0, 4'b0100, 4'b0000, 1, "s2_hold2",    1, 1, 2, 0, 0);
        step(0, 4'b0000, 4'b0100, 1, "s2_release",  0, 0, 0, 1, 3);

        // Rotation with single-beat transfers
        step(1, 4'b0000, 4'b0000, 0, "s3_rst",      1, 0, 0, 1, 0);
        step(0, 4'b1111, 4'b1111, 1, "s3_rot0",     1, 1, 0, 1, 0);
        step(0, 4'b1111, 4'b1111, 1, "s3_rot1",     1, 1, 1, 1, 1);
        step(0, 4'b1111, 4'b1111, 1, "s3_rot2",     1, 1, 2, 1, 2);
        step(0, 4'b1111, 4'b1111, 1, "s3_rot3",     1, 1, 3, 1, 3);
        step(0, 4'b1111, 4'b1111, 1, "s3_rot4",     1, 1, 0, 1, 0);

        // Lock across non-final beats; stray last bits of other requesters ignored
        step(1, 4'b0000, 4'b0000, 0, "s4_rst",      1, 0, 0, 1, 0);
        step(0, 4'b0011, 4'b0000, 0, "s4_grant",    1, 1, 0, 1, 0);
        step(0, 4'b0011, 4'b0000, 1, "s4_beat1",    1, 1, 0, 1, 0);
        step(0, 4'b0011, 4'b0010, 1, "s4_beat2",    1, 1, 0, 1, 0);
        step(0, 4'b0011, 4'b0000, 1, "s4_beat3",    1, 1, 0, 1, 0);
        step(0, 4'b0011, 4'b0001, 0, "s4_last_noack", 1, 1, 0, 1, 0);
        step(0, 4'b0011, 4'b0001, 1, "s4_final",    1, 1, 1, 1, 1);

        // Wrap-around of the search
        step(1, 4'b0000, 4'b0000, 0, "s5_rst",      1, 0, 0, 1, 0);
        step(0, 4'b0100, 4'b0000, 0, "s5_grant2",   1, 1, 2, 1, 0);
        step(0, 4'b1001, 4'b0100, 1, "s5_wrap3",    1, 1, 3, 1, 3);
        step(0, 4'b0101, 4'b1000, 1, "s5_wrap0",    1, 1, 0, 1, 0);
        step(0, 4'b0001, 4'b0001, 1, "s5_sole",     1, 1, 0, 1, 1);
        step(0, 4'b0000, 4'b0001, 1, "s5_idle",     1, 0, 0, 1, 1);

        // Stray ack while idle, then reset mid-transfer
        step(1, 4'b0000, 4'b0000, 0, "s6_rst",      1, 0, 0, 1, 0);
        step(0, 4'b0000, 4'b1111, 1, "s6_stray_ack", 1, 0, 0, 1, 0);
        step(0, 4'b0010, 4'b0000, 0, "s6_grant1",   1, 1, 1, 1, 0);
        step(0, 4'b0100, 4'b0010, 1, "s6_b2b2",     1, 1, 2, 1, 2);
        step(0, 4'b0100, 4'b0000, 1, "s6_beat",     1, 1, 2, 1, 2);
        step(1, 4'b0100, 4'b0100, 1, "s6_rst_mid",  1, 0, 0, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, "s6_after",    1, 0, 0, 1, 0);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
